// File: rtl/via_gpio_port.sv
// Pad-side companion to the VIA GPIO block: pad drive, input sync/filter,
// 6522-style read-back and sticky per-pin change flags with masked interrupt.
module via_gpio_port #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned ARM_LEN    = 8
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic [7:0] gpio_ora,
  input  logic [7:0] gpio_orb,
  input  logic [7:0] gpio_ddra,
  input  logic [7:0] gpio_ddrb,
  output logic [7:0] gpio_ira,
  output logic [7:0] gpio_irb,
  input  logic [7:0] pad_a_i,
  input  logic [7:0] pad_b_i,
  output logic [7:0] pad_a_o,
  output logic [7:0] pad_a_oe,
  output logic [7:0] pad_b_o,
  output logic [7:0] pad_b_oe,
  output logic [7:0] chg_a_o,
  output logic [7:0] chg_b_o,
  input  logic [7:0] chg_clr_a_i,
  input  logic [7:0] chg_clr_b_i,
  input  logic [7:0] irq_mask_a_i,
  input  logic [7:0] irq_mask_b_i,
  output logic       irq_o
);

  localparam int unsigned NPIN = 16;
  localparam int unsigned CW   = 8;

  // Pins are handled as one 16-bit vector: [7:0] = port A, [15:8] = port B.
  logic [NPIN-1:0]         pad_in_c;
  logic [NPIN-1:0]         ddr_c;
  logic [NPIN-1:0]         clr_c;
  logic [NPIN-1:0]         mask_c;
  logic [NPIN-1:0]         s1_q, s2_q;
  logic [NPIN-1:0]         st_q, st_d;
  logic [NPIN-1:0]         upd_c;
  logic [NPIN-1:0]         chg_q, chg_d;
  logic [NPIN-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]           arm_q, arm_d;
  logic                    armed_c;
  logic                    irq_q, irq_d;

  assign pad_in_c = {pad_b_i, pad_a_i};
  assign ddr_c    = {gpio_ddrb, gpio_ddra};
  assign clr_c    = {chg_clr_b_i, chg_clr_a_i};
  assign mask_c   = {irq_mask_b_i, irq_mask_a_i};

  // Glitch filter: st follows s2 only after FILTER_LEN consecutive differing cycles.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    upd_c = '0;
    for (int i = 0; i < NPIN; i++) begin
      if (s2_q[i] == st_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
        st_d[i]  = s2_q[i];
        cnt_d[i] = '0;
        upd_c[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Arm window keeps the post-reset filter settle from raising change flags.
  always_comb begin
    armed_c = (arm_q == CW'(ARM_LEN));
    arm_d   = armed_c ? arm_q : arm_q + CW'(1);
    chg_d   = (upd_c & ~ddr_c & {NPIN{armed_c}}) | (chg_q & ~clr_c);
    irq_d   = |(chg_q & mask_c);
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      s1_q  <= '0;
      s2_q  <= '0;
      st_q  <= '0;
      cnt_q <= '0;
      arm_q <= '0;
      chg_q <= '0;
      irq_q <= 1'b0;
    end else begin
      s1_q  <= pad_in_c;
      s2_q  <= s1_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      arm_q <= arm_d;
      chg_q <= chg_d;
      irq_q <= irq_d;
    end
  end

  assign pad_a_o  = gpio_ora;
  assign pad_a_oe = gpio_ddra;
  assign pad_b_o  = gpio_orb;
  assign pad_b_oe = gpio_ddrb;

  // PA always reads the filtered pin; PB output pins read back ORB.
  assign gpio_ira = st_q[7:0];
  assign gpio_irb = (gpio_ddrb & gpio_orb) | (~gpio_ddrb & st_q[15:8]);
  assign chg_a_o  = chg_q[7:0];
  assign chg_b_o  = chg_q[15:8];
  assign irq_o    = irq_q;

endmodule
